// File: rtl/data_mem_responder.sv
// data_mem_responder: latency-modelled block-refill/write-through memory responder; optional byte strobes via WR_STROBE_EN
module data_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int BLOCK_WORDS   = 4,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_read_en,
  input  logic                           mem_write_en,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_wr_data,
`ifdef WR_STROBE_EN
  input  logic [DATA_WIDTH/8-1:0]        mem_wr_strb,
`endif
  output logic [DATA_WIDTH-1:0]          refill_data,
  output logic                           refill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] refill_idx,
  output logic                           ready_to_read,
  output logic                           finished_writing,
  output logic                           busy
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int BWW = $clog2(BLOCK_WORDS);
  localparam int ML = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW = $clog2(ML + 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, DONE} state_t;
  state_t state, next_state;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IW-1:0] widx;
  logic [DATA_WIDTH-1:0] wdata;
  logic [CW-1:0] cnt;
  logic is_wr;
  logic [BWW-1:0] nidx;
  logic [IW-1:0] beat_addr;
  logic accept;
`ifdef WR_STROBE_EN
  logic [DATA_WIDTH/8-1:0] wstrb;
`endif
  assign accept = state == IDLE && (mem_write_en || mem_read_en);
  assign nidx = state == RD_BURST ? refill_idx + 1'b1 : '0;
  assign beat_addr = {widx[IW-1:BWW], nidx};
  assign refill_valid = state == RD_BURST;
  assign ready_to_read = state == DONE && !is_wr;
  assign finished_writing = state == DONE && is_wr;
  assign busy = state != IDLE;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = mem_write_en ? WR_WAIT : mem_read_en ? RD_WAIT : IDLE;
      RD_WAIT:  next_state = cnt == '0 ? RD_BURST : RD_WAIT;
      RD_BURST: next_state = refill_idx == BWW'(BLOCK_WORDS - 1) ? DONE : RD_BURST;
      WR_WAIT:  next_state = cnt == '0 ? DONE : WR_WAIT;
      default:  next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      is_wr       <= 1'b0;
      refill_idx  <= '0;
      refill_data <= '0;
    end else begin
      if (accept) begin
        widx  <= IW'(mem_addr >> 2);
        wdata <= mem_wr_data;
        is_wr <= mem_write_en;
        cnt   <= mem_write_en ? CW'(WRITE_LATENCY - 1) : CW'(READ_LATENCY - 1);
`ifdef WR_STROBE_EN
        wstrb <= mem_wr_strb;
`endif
      end else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (next_state == RD_BURST) begin
        refill_idx  <= nidx;
        refill_data <= mem[beat_addr];
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset && state == WR_WAIT && cnt == '0)
`ifdef WR_STROBE_EN
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
`else
      mem[widx] <= wdata;
`endif
endmodule
